// File: rtl/sipo_rx_ctrl.sv
`default_nettype none
// ============================================================================
// sipo_rx_ctrl : framed serial-in/parallel-out receiver with valid/ready output
// Rev 1.0
// ============================================================================
module sipo_rx_ctrl #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             si_i,
  output logic [WIDTH-1:0] q_o,
  output logic             q_valid_o,
  input  logic             q_ready_i,
  output logic             busy_o,
  output logic             frame_err_o,
  output logic             overrun_o
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bcnt_q, bcnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic             busy_q, busy_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  logic             w_s;
  logic             w_cnt_zero;
  logic [WIDTH-1:0] w_sr_shift;

  assign w_s        = sync2_q;
  assign w_cnt_zero = (cnt_q == '0);

  // New bits enter at the MSB so the first bit ends up in sr[0]
  generate
    if (WIDTH == 1) begin : g_shift_one
      assign w_sr_shift = w_s;
    end else begin : g_shift_multi
      assign w_sr_shift = {w_s, sr_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bcnt_q      <= '0;
      sr_q        <= '0;
      q_q         <= '0;
      q_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= si_i;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bcnt_q      <= bcnt_d;
      sr_q        <= sr_d;
      q_q         <= q_d;
      q_valid_q   <= q_valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bcnt_d      = bcnt_q;
    sr_d        = sr_q;
    q_d         = q_q;
    q_valid_d   = q_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (q_valid_q && q_ready_i) begin
      q_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!w_s) begin
          cnt_d   = CNT_HALF;
          state_d = S_START;
        end
      end
      S_START: begin
        if (!w_cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!w_s) begin
          cnt_d   = CNT_FULL;
          bcnt_d  = '0;
          state_d = S_DATA;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (!w_cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          sr_d  = w_sr_shift;
          cnt_d = CNT_FULL;
          if (bcnt_q == BIT_LAST) begin
            state_d = S_STOP;
          end else begin
            bcnt_d = bcnt_q + BIT_W'(1);
          end
        end
      end
      S_STOP: begin
        if (!w_cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (w_s) begin
          state_d = S_IDLE;
          // A word still held and not taken this edge makes the new one lost
          if (!q_valid_q || q_ready_i) begin
            q_d       = sr_q;
            q_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          frame_err_d = 1'b1;
          sr_d        = '0;
          state_d     = S_BREAK;
        end
      end
      S_BREAK: begin
        if (w_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign q_o         = q_q;
  assign q_valid_o   = q_valid_q;
  assign busy_o      = busy_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_sipo_rx_ctrl.sv
`default_nettype none
// ============================================================================
// tb_sipo_rx_ctrl : directed + random frames against a frame-level timing model
// Rev 1.0
// ============================================================================
module tb_sipo_rx_ctrl;

  logic       clk;
  logic       rst_n;
  logic       si;
  logic [3:0] q;
  logic       q_valid;
  logic       q_ready;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  sipo_rx_ctrl #(
    .WIDTH        (4),
    .CLKS_PER_BIT (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .si_i        (si),
    .q_o         (q),
    .q_valid_o   (q_valid),
    .q_ready_i   (q_ready),
    .busy_o      (busy),
    .frame_err_o (frame_err),
    .overrun_o   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] data;
    bit         good;
  } ev_t;

  ev_t        events[$];
  int         cyc       = 0;
  int         n_checks  = 0;
  int         n_errors  = 0;
  int         busy_from = 1;
  int         busy_to   = 0;
  bit         rand_ready = 1'b0;
  logic [3:0] exp_q     = 4'h0;
  logic       exp_valid = 1'b0;
  logic       exp_fe    = 1'b0;
  logic       exp_ov    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: advance the frame-level model at the edge, then compare outputs
  task automatic tick();
    logic r;
    logic v0;
    ev_t  ev;
    @(posedge clk);
    cyc++;
    r      = q_ready;
    v0     = exp_valid;
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    if (!rst_n) begin
      exp_q     = 4'h0;
      exp_valid = 1'b0;
      events.delete();
      busy_from = 1;
      busy_to   = 0;
    end else begin
      if (v0 && r) exp_valid = 1'b0;
      if (events.size() > 0 && events[0].cyc == cyc) begin
        ev = events.pop_front();
        if (!ev.good) begin
          exp_fe = 1'b1;
        end else if (!v0 || r) begin
          exp_q     = ev.data;
          exp_valid = 1'b1;
        end else begin
          exp_ov = 1'b1;
        end
      end
    end
    #1;
    chk("q",         32'(q),         32'(exp_q));
    chk("q_valid",   32'(q_valid),   32'(exp_valid));
    chk("busy",      32'(busy),      32'((cyc >= busy_from) && (cyc <= busy_to)));
    chk("frame_err", 32'(frame_err), 32'(exp_fe));
    chk("overrun",   32'(overrun),   32'(exp_ov));
    if (rand_ready) q_ready = 1'($urandom_range(0, 1));
  endtask

  // Line starts low just after edge X: result visible after edge X+25,
  // receiver busy after edges X+3 .. X+24 (or until the break clears).
  task automatic send_frame(input logic [3:0] data, input bit good, input int extra_low);
    ev_t ev;
    int  x;
    x       = cyc;
    ev.cyc  = x + 25;
    ev.data = data;
    ev.good = good;
    events.push_back(ev);
    busy_from = x + 3;
    busy_to   = good ? x + 24 : 32'h7fffffff;
    si = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      si = data[i];
      repeat (4) tick();
    end
    si = good;
    repeat (4) tick();
    if (!good) begin
      repeat (extra_low) tick();
      si      = 1'b1;
      busy_to = cyc + 2;
      repeat (3) tick();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_q"},         32'(q),         32'h0);
    chk({tag, "_q_valid"},   32'(q_valid),   32'h0);
    chk({tag, "_busy"},      32'(busy),      32'h0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    chk({tag, "_overrun"},   32'(overrun),   32'h0);
  endtask

  initial begin
    logic [3:0] d;
    bit         g;
    int         x;
    rst_n   = 1'b1;
    si      = 1'b1;
    q_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Basic frame 1,1,0,1 -> 0xB, consumed at once
    send_frame(4'hB, 1'b1, 0);
    repeat (4) tick();

    // One-cycle low glitch: START visited, no word, no pulses
    x = cyc;
    busy_from = x + 3;
    busy_to   = x + 4;
    si = 1'b0;
    tick();
    si = 1'b1;
    repeat (6) tick();

    // Bad stop, line low three more bit periods, then a good frame
    send_frame(4'h7, 1'b0, 12);
    repeat (3) tick();
    send_frame(4'h5, 1'b1, 0);
    repeat (3) tick();

    // Two words with consumer stalled: second one overruns
    q_ready = 1'b0;
    send_frame(4'h3, 1'b1, 0);
    send_frame(4'hC, 1'b1, 0);
    repeat (3) tick();
    q_ready = 1'b1;
    repeat (3) tick();

    // Ready only in the completion cycle of the second word
    q_ready = 1'b0;
    send_frame(4'hA, 1'b1, 0);
    repeat (2) tick();
    send_frame(4'h6, 1'b1, 0);
    q_ready = 1'b1;
    tick();
    q_ready = 1'b0;
    repeat (3) tick();
    q_ready = 1'b1;
    repeat (2) tick();

    // Asynchronous reset in the middle of the data bits
    x = cyc;
    busy_from = x + 3;
    busy_to   = 32'h7fffffff;
    si = 1'b0;
    repeat (4) tick();
    si = 1'b1;
    repeat (8) tick();
    si = 1'b0;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    si = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    send_frame(4'h9, 1'b1, 0);
    repeat (3) tick();

    // Random frames, random gaps and random consumer stalls
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      d = 4'($urandom);
      g = ($urandom_range(0, 7) != 0);
      send_frame(d, g, int'($urandom_range(0, 6)));
      repeat ($urandom_range(0, 4)) tick();
    end
    rand_ready = 1'b0;
    q_ready    = 1'b1;
    repeat (30) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
